// File: rtl/alu_shift_seq.sv
// Multi-cycle shift/rotate sequencer: drives the shared ALU one single-bit step
// per clock and accumulates the shifted value and PSW flags.
module alu_shift_seq #(
  parameter logic [4:0] COUNT_MASK = 5'h1F,
  parameter int         CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic             size,
  input  logic [15:0]      operand,
  input  logic [CNT_W-1:0] count,
  input  logic [5:0]       flags_in,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [15:0]      result,
  output logic [5:0]       flags_out,
  output logic [4:0]       alu_op,
  output logic             alu_size,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  input  logic [15:0]      alu_r,
  input  logic [5:0]       alu_flags
);

  localparam int          DATA_W  = 16;
  localparam logic [4:0]  OP_AND  = 5'd0;
  localparam logic [4:0]  OP_ROL  = 5'd6;
  localparam logic [4:0]  OP_ROR  = 5'd7;
  localparam logic [4:0]  OP_SHL  = 5'd10;
  localparam logic [4:0]  OP_SHR  = 5'd11;
  localparam logic [4:0]  OP_SHRA = 5'd12;

  localparam int F_Z  = 5;
  localparam int F_S  = 4;
  localparam int F_P  = 3;
  localparam int F_V  = 2;
  localparam int F_CY = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [4:0] o);
    return (o == OP_ROL) || (o == OP_ROR) || (o == OP_SHL) ||
           (o == OP_SHR) || (o == OP_SHRA);
  endfunction

  function automatic logic is_rotate(input logic [4:0] o);
    return (o == OP_ROL) || (o == OP_ROR);
  endfunction

  // Rotates leave Z/S/P untouched; AC is never touched by this sequencer.
  function automatic logic [5:0] merge_flags(input logic [5:0] cur,
                                             input logic [5:0] alu,
                                             input logic       rot);
    logic [5:0] f;
    f       = cur;
    f[F_CY] = alu[F_CY];
    f[F_V]  = alu[F_V];
    if (!rot) begin
      f[F_Z] = alu[F_Z];
      f[F_S] = alu[F_S];
      f[F_P] = alu[F_P];
    end
    return f;
  endfunction

  state_t              state;
  logic [4:0]          rem;
  logic [4:0]          op_q;
  logic                size_q;
  logic [DATA_W-1:0]   acc;
  logic [5:0]          flg;
  logic [4:0]          count_m;
  logic [5:0]          step_flags;

  assign count_m    = count[4:0] & COUNT_MASK;
  assign step_flags = merge_flags(flg, alu_flags, is_rotate(op_q));

  // The sequencer owns the ALU input bus only while stepping.
  assign alu_op   = (state == STEP) ? op_q   : OP_AND;
  assign alu_size = (state == STEP) ? size_q : 1'b0;
  assign alu_a    = (state == STEP) ? acc    : '0;
  assign alu_b    = (state == STEP) ? 16'd1  : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rem       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      result    <= '0;
      flags_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          illegal <= 1'b0;
          if (start) begin
            rem <= count_m;
            if (!is_shift(op)) begin
              state     <= FIN;
              done      <= 1'b1;
              illegal   <= 1'b1;
              result    <= operand;
              flags_out <= flags_in;
            end else if (count_m == 5'd0) begin
              state     <= FIN;
              done      <= 1'b1;
              result    <= operand;
              flags_out <= flags_in;
            end else begin
              state <= STEP;
              busy  <= 1'b1;
            end
          end
        end
        STEP: begin
          if (rem != 5'd0) begin
            rem <= rem - 5'd1;
          end
          // Last step: publish the ALU's final value directly with done.
          if (rem <= 5'd1) begin
            state     <= FIN;
            busy      <= 1'b0;
            done      <= 1'b1;
            result    <= alu_r;
            flags_out <= step_flags;
          end
        end
        FIN: begin
          state   <= IDLE;
          done    <= 1'b0;
          illegal <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Working datapath registers; only meaningful while state is STEP.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && start) begin
      op_q   <= op;
      size_q <= size;
      acc    <= operand;
      flg    <= flags_in;
    end else if (state == STEP) begin
      acc <= alu_r;
      flg <= step_flags;
    end
  end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Directed bench for alu_shift_seq with a behavioural single-bit shift ALU.
module tb_alu_shift_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  op;
  logic        size;
  logic [15:0] operand;
  logic [7:0]  count;
  logic [5:0]  flags_in;
  logic        busy, done, illegal;
  logic [15:0] result;
  logic [5:0]  flags_out;
  logic [4:0]  alu_op;
  logic        alu_size;
  logic [15:0] alu_a, alu_b, alu_r;
  logic [5:0]  alu_flags;

  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] a_log [0:40];

  always #5 clk = ~clk;

  alu_shift_seq #(.COUNT_MASK(5'h1F), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .size(size),
    .operand(operand), .count(count), .flags_in(flags_in),
    .busy(busy), .done(done), .illegal(illegal), .result(result),
    .flags_out(flags_out), .alu_op(alu_op), .alu_size(alu_size),
    .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r), .alu_flags(alu_flags)
  );

  // Reference ALU: one-bit shift/rotate; byte mode keeps the upper byte.
  // AC is always reported as 1 so any leak into flags_out is visible.
  always_comb begin
    logic c, mo, mn;
    alu_r = alu_a;
    c = 1'b0;
    case (alu_op)
      5'd6:  begin
        if (alu_size) begin alu_r = {alu_a[14:0], alu_a[15]}; c = alu_a[15]; end
        else begin alu_r = {alu_a[15:8], alu_a[6:0], alu_a[7]}; c = alu_a[7]; end
      end
      5'd7:  begin
        if (alu_size) alu_r = {alu_a[0], alu_a[15:1]};
        else alu_r = {alu_a[15:8], alu_a[0], alu_a[7:1]};
        c = alu_a[0];
      end
      5'd10: begin
        if (alu_size) begin alu_r = {alu_a[14:0], 1'b0}; c = alu_a[15]; end
        else begin alu_r = {alu_a[15:8], alu_a[6:0], 1'b0}; c = alu_a[7]; end
      end
      5'd11: begin
        if (alu_size) alu_r = {1'b0, alu_a[15:1]};
        else alu_r = {alu_a[15:8], 1'b0, alu_a[7:1]};
        c = alu_a[0];
      end
      5'd12: begin
        if (alu_size) alu_r = {alu_a[15], alu_a[15:1]};
        else alu_r = {alu_a[15:8], alu_a[7], alu_a[7:1]};
        c = alu_a[0];
      end
      default: alu_r = alu_a;
    endcase
    mo = alu_size ? alu_a[15] : alu_a[7];
    mn = alu_size ? alu_r[15] : alu_r[7];
    alu_flags = {(alu_size ? (alu_r == 16'd0) : (alu_r[7:0] == 8'd0)),
                 mn, ~^alu_r[7:0], mo ^ mn, c, 1'b1};
  end

  task automatic run_op(input logic [4:0] o, input logic sz, input logic [15:0] opd,
                        input logic [7:0] cnt, input logic [5:0] fl,
                        output int done_cyc, output int busy_n, output int first_busy,
                        output int bad_bus, output logic ill_seen);
    op = o; size = sz; operand = opd; count = cnt; flags_in = fl; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cyc = -1; busy_n = 0; first_busy = -1; bad_bus = 0; ill_seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) begin
        busy_n++;
        if (first_busy < 0) first_busy = k;
        if (alu_b !== 16'd1 || alu_op !== o || alu_size !== sz) bad_bus++;
        a_log[k] = alu_a;
      end
      if (done) begin
        done_cyc = k;
        ill_seen = illegal;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; size = 1'b0; operand = '0; count = '0; flags_in = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_cmp++;
    if ({busy, done, illegal, result, flags_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: got busy=%b done=%b ill=%b res=%h fl=%h, want all 0",
               busy, done, illegal, result, flags_out);
    end
    n_cmp++;
    if ({alu_op, alu_size, alu_a, alu_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_alu: got op=%0d sz=%b a=%h b=%h, want all 0", alu_op, alu_size, alu_a, alu_b);
    end
  endtask

  task automatic test_rol_byte();
    int dc, bn, fb, bb; logic il;
    run_op(5'd6, 1'b0, 16'h0081, 8'd1, 6'h00, dc, bn, fb, bb, il);
    n_cmp++;
    if (dc !== 2) begin n_fail++; $display("FAIL rol_done_cycle: got %0d want 2", dc); end
    n_cmp++;
    if (result !== 16'h0003) begin n_fail++; $display("FAIL rol_result: got %h want 0003", result); end
    n_cmp++;
    if (flags_out !== 6'h06) begin n_fail++; $display("FAIL rol_flags: got %h want 06", flags_out); end
    n_cmp++;
    if (bn !== 1 || bb !== 0) begin
      n_fail++; $display("FAIL rol_busy: got busy_cycles=%0d bad_bus=%0d want 1/0", bn, bb);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_shl_word();
    int dc, bn, fb, bb; logic il;
    run_op(5'd10, 1'b1, 16'h0001, 8'd4, 6'h3F, dc, bn, fb, bb, il);
    n_cmp++;
    if (dc !== 5 || bn !== 4 || fb !== 1) begin
      n_fail++; $display("FAIL shl_timing: got done=%0d busy_n=%0d first=%0d want 5/4/1", dc, bn, fb);
    end
    n_cmp++;
    if (bb !== 0) begin n_fail++; $display("FAIL shl_alu_bus: got %0d bad cycles want 0", bb); end
    n_cmp++;
    if (a_log[1] !== 16'h1 || a_log[2] !== 16'h2 || a_log[3] !== 16'h4 || a_log[4] !== 16'h8) begin
      n_fail++; $display("FAIL shl_alu_a: got %h %h %h %h want 1 2 4 8",
                         a_log[1], a_log[2], a_log[3], a_log[4]);
    end
    n_cmp++;
    if (result !== 16'h0010) begin n_fail++; $display("FAIL shl_result: got %h want 0010", result); end
    n_cmp++;
    if (flags_out !== 6'h01) begin n_fail++; $display("FAIL shl_flags: got %h want 01", flags_out); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL shl_busy_in_done: got %b want 0", busy); end
    @(posedge clk); #1;
    n_cmp++;
    if ({done, alu_op, alu_b} !== '0) begin
      n_fail++; $display("FAIL shl_release: got done=%b op=%0d b=%h want 0", done, alu_op, alu_b);
    end
  endtask

  task automatic test_zero_count();
    int dc, bn, fb, bb; logic il;
    run_op(5'd11, 1'b1, 16'h8000, 8'd0, 6'h2A, dc, bn, fb, bb, il);
    n_cmp++;
    if (dc !== 1 || bn !== 0) begin
      n_fail++; $display("FAIL zero_timing: got done=%0d busy_n=%0d want 1/0", dc, bn);
    end
    n_cmp++;
    if (result !== 16'h8000 || flags_out !== 6'h2A) begin
      n_fail++; $display("FAIL zero_out: got %h/%h want 8000/2a", result, flags_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_count_mask();
    int dc, bn, fb, bb; logic il;
    run_op(5'd11, 1'b1, 16'h0004, 8'h21, 6'h3F, dc, bn, fb, bb, il);
    n_cmp++;
    if (dc !== 2 || bn !== 1) begin
      n_fail++; $display("FAIL mask_timing: got done=%0d busy_n=%0d want 2/1", dc, bn);
    end
    n_cmp++;
    if (result !== 16'h0002 || flags_out !== 6'h01) begin
      n_fail++; $display("FAIL mask_out: got %h/%h want 0002/01", result, flags_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    int dc, bn, fb, bb; logic il;
    run_op(5'd1, 1'b1, 16'h1234, 8'd3, 6'h15, dc, bn, fb, bb, il);
    n_cmp++;
    if (dc !== 1 || il !== 1'b1 || bn !== 0) begin
      n_fail++; $display("FAIL ill_pulse: got done=%0d ill=%b busy_n=%0d want 1/1/0", dc, il, bn);
    end
    n_cmp++;
    if (result !== 16'h1234 || flags_out !== 6'h15) begin
      n_fail++; $display("FAIL ill_out: got %h/%h want 1234/15", result, flags_out);
    end
    // A start during the completion pulse must be dropped.
    op = 5'd10; size = 1'b1; operand = 16'h5555; count = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || illegal !== 1'b0 || result !== 16'h1234) begin
        n_fail++; $display("FAIL ill_ignore_start: got busy=%b done=%b ill=%b res=%h want 0/0/0/1234",
                           busy, done, illegal, result);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int dc, bn, fb, bb; logic il;
    run_op(5'd10, 1'b0, 16'hAB80, 8'd1, 6'h00, dc, bn, fb, bb, il);
    n_cmp++;
    if (dc !== 2 || result !== 16'hAB00 || flags_out !== 6'h2E) begin
      n_fail++; $display("FAIL shl_byte: got done=%0d res=%h fl=%h want 2/ab00/2e", dc, result, flags_out);
    end
    @(posedge clk); #1;
    run_op(5'd12, 1'b1, 16'h8004, 8'd2, 6'h00, dc, bn, fb, bb, il);
    n_cmp++;
    if (dc !== 3 || result !== 16'hE001 || flags_out !== 6'h10) begin
      n_fail++; $display("FAIL shra_word: got done=%0d res=%h fl=%h want 3/e001/10", dc, result, flags_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int dc, bn, fb, bb; logic il;
    op = 5'd10; size = 1'b1; operand = 16'h00FF; count = 8'd8; flags_in = 6'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done, illegal, result, flags_out, alu_op, alu_size, alu_a, alu_b} !== '0) begin
      n_fail++; $display("FAIL abort_zero: got busy=%b done=%b res=%h fl=%h op=%0d a=%h b=%h want 0",
                         busy, done, result, flags_out, alu_op, alu_a, alu_b);
    end
    // start coincident with reset must not be accepted
    op = 5'd10; operand = 16'h0001; count = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_start_ignored: got busy=%b done=%b want 0/0", busy, done);
    end
    run_op(5'd7, 1'b0, 16'h0001, 8'd1, 6'h00, dc, bn, fb, bb, il);
    n_cmp++;
    if (dc !== 2 || result !== 16'h0080 || flags_out !== 6'h06) begin
      n_fail++; $display("FAIL ror_after_reset: got done=%0d res=%h fl=%h want 2/0080/06",
                         dc, result, flags_out);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_rol_byte();
    test_shl_word();
    test_zero_count();
    test_count_mask();
    test_illegal();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_shift_seq.md
Name: alu_shift_seq

Overview:
- Multi-cycle sequencer for shift/rotate-by-count instructions (ROL, ROR, SHL, SHR, SHRA).
- Drives the shared combinational ALU one single-bit step per clock and accumulates the result and flags.
- Sits between the execution-unit microsequencer and the ALU instance; owns the ALU input bus only while busy.

Parameters:
- COUNT_MASK, 5'h1F, AND-mask applied to the raw count at start (5-bit count masking).
- CNT_W, 8, width of the raw count input.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- op  in  5  ALU opcode: ROL=6, ROR=7, SHL=10, SHR=11, SHRA=12
- size  in  1  0=byte, 1=word
- operand  in  16  value to shift
- count  in  CNT_W  raw shift count
- flags_in  in  6  current PSW flags {Z,S,P,V,CY,AC}, bit indices 5..0
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle completion pulse
- illegal  out  1  one-cycle pulse with done when op is unsupported
- result  out  16  final value, held until next accepted start
- flags_out  out  6  final flags, held until next accepted start
- alu_op  out  5  to ALU
- alu_size  out  1  to ALU
- alu_a  out  16  to ALU
- alu_b  out  16  to ALU
- alu_r  in  16  from ALU
- alu_flags  in  6  from ALU

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, done=0, illegal=0, result=0, flags_out=0, alu_op=0 (AND), alu_size=0, alu_a=0, alu_b=0. Reset mid-operation aborts immediately; no partial result is kept.
- States: IDLE, STEP, FIN.
- IDLE:
  - On start, latch op, size, operand into acc, flags_in into flg, and rem = count & COUNT_MASK.
  - Unsupported op: go to FIN with illegal flagged, acc=operand, flg=flags_in.
  - rem==0: go to FIN with result=operand and flags unchanged.
  - Otherwise go to STEP.
- STEP:
  - Outputs: alu_op=latched op, alu_size=latched size, alu_a=acc, alu_b=16'd1.
  - Each clock: acc<=alu_r; flg[CY]<=alu_flags[1]; flg[V]<=alu_flags[2].
  - For SHL/SHR/SHRA also take Z,S,P (bits 5,4,3) from alu_flags. For ROL/ROR, Z/S/P are kept. AC is never modified.
  - rem<=rem-1; when rem==1, go to FIN.
- FIN (one cycle): done=1; illegal=1 if flagged; result<=acc; flags_out<=flg; then IDLE. busy=0 in FIN.
- Outside STEP, ALU outputs return to the reset values.
- Latency: accepted start at edge 0, N steps at edges 1..N, done high during cycle N+1. N=0 or illegal op gives done at cycle 1.
- busy is high during STEP cycles only.
- Byte mode: upper byte of result equals upper byte of acc as returned by the ALU. Consumers write back only the low byte.
- start while not IDLE is ignored, with no queueing. start coincident with reset is ignored.
- Counter wraps never: rem is only decremented while >0.

Test Plan:
- ROL byte, operand=0x0081, count=1, flags_in=0 -> done at cycle 2; result[7:0]=0x03; flags_out[CY]=1; busy high exactly 1 cycle.
- SHL word, operand=0x0001, count=4 -> busy cycles 1-4; alu_b=1 each step; done cycle 5; result=0x0010; CY=0, Z=0, S=0.
- SHR word, operand=0x8000, count=0, flags_in=6'h2A -> done cycle 1; result=0x8000; flags_out=6'h2A; no STEP entered.
- Count masking, SHR word, operand=0x0004, count=0x21 -> one step only; result=0x0002; done cycle 2.
- op=ADD(1), start -> done and illegal pulse together at cycle 1; result=operand; flags_out=flags_in; second start during illegal pulse ignored.
- SHL word, count=8, reset asserted at step 3, then start ROR byte 0x01 count=1 -> all outputs zero after reset; new op completes normally with result[7:0]=0x80 and CY=1.
